// File: rtl/ysyx_23060201_idu_stage.sv
// rtl/ysyx_23060201_idu_stage.sv - pipelined RV32I/RV64I decode stage with optional 2-entry skid buffer
module ysyx_23060201_idu_stage #(
  parameter int XLEN  = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [6:0]       out_op,
  output logic [4:0]       out_rd,
  output logic [2:0]       out_func3,
  output logic [XLEN-1:0]  out_imm,
  output logic [1:0]       out_ren,
  output logic [4:0]       out_raddr1,
  output logic [4:0]       out_raddr2,
  output logic             out_wen,
  output logic             out_trap,
  output logic             out_illegal,
  output logic             trap_pulse,
  output logic [CNT_W-1:0] dec_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_S      = 7'b0100011;
  localparam logic [6:0] OP_B      = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_32     = 7'b0111011;
  localparam bit         RV64      = (XLEN == 64);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [6:0]      op;
    logic [4:0]      rd;
    logic [2:0]      func3;
    logic [XLEN-1:0] imm;
    logic [1:0]      ren;
    logic [4:0]      raddr1;
    logic [4:0]      raddr2;
    logic            wen;
    logic            trap;
    logic            illegal;
  } bundle_t;

  // Immediates are built at 64 bits and truncated, so one set serves both XLENs.
  logic [63:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm64;
  assign imm_i = {{52{in_inst[31]}}, in_inst[31:20]};
  assign imm_s = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
  assign imm_b = {{52{in_inst[31]}}, in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0};
  assign imm_u = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
  assign imm_j = {{44{in_inst[31]}}, in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0};

  bundle_t dec;

  always_comb begin
    dec        = '0;
    imm64      = '0;
    dec.pc     = in_pc;
    dec.op     = in_inst[6:0];
    dec.rd     = in_inst[11:7];
    dec.func3  = in_inst[14:12];
    dec.raddr1 = in_inst[19:15];
    dec.raddr2 = in_inst[24:20];
    dec.trap   = (in_inst == 32'h00100073);
    case (in_inst[6:0])
      OP_R:                     begin dec.ren = 2'b11; dec.wen = 1'b1; end
      OP_I, OP_LOAD, OP_JALR:   begin dec.ren = 2'b01; dec.wen = 1'b1; imm64 = imm_i; end
      OP_S:                     begin dec.ren = 2'b11; imm64 = imm_s; end
      OP_B:                     begin dec.ren = 2'b11; imm64 = imm_b; end
      OP_LUI:                   begin dec.wen = 1'b1; imm64 = imm_u; end
      OP_AUIPC:                 begin dec.wen = 1'b1; imm64 = imm_u; dec.func3 = 3'b0; end
      OP_JAL:                   begin dec.wen = 1'b1; imm64 = imm_j; dec.func3 = 3'b0; end
      OP_SYSTEM:                ;
      OP_IMM32: begin
        if (RV64) begin dec.ren = 2'b01; dec.wen = 1'b1; imm64 = imm_i; end
        else dec.illegal = 1'b1;
      end
      OP_32: begin
        if (RV64) begin dec.ren = 2'b11; dec.wen = 1'b1; end
        else dec.illegal = 1'b1;
      end
      default:                  dec.illegal = 1'b1;
    endcase
    if (dec.rd == 5'd0) dec.wen = 1'b0;
    dec.imm = imm64[XLEN-1:0];
  end

  // e0 is always the head presented on out_*; e1 only fills while e0 is stalled.
  bundle_t          e0_q, e0_d, e1_q, e1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             trap_pulse_q, trap_pulse_d;
  logic [CNT_W-1:0] dec_cnt_q, dec_cnt_d;
  logic             push, pop;

  assign out_valid = (cnt_q != 2'd0);
  assign in_ready  = (SKID != 0) ? in_ready_q : (!out_valid || out_ready);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready;

  always_comb begin
    e0_d  = e0_q;
    e1_d  = e1_q;
    cnt_d = cnt_q;
    if (flush) begin
      cnt_d = 2'd0;
    end else begin
      case (cnt_q)
        2'd0: if (push) begin e0_d = dec; cnt_d = 2'd1; end
        2'd1: begin
          if (push && pop) e0_d = dec;
          else if (push) begin e1_d = dec; cnt_d = 2'd2; end
          else if (pop) cnt_d = 2'd0;
        end
        default: if (pop) begin e0_d = e1_q; cnt_d = 2'd1; end
      endcase
    end
    in_ready_d   = (cnt_d != 2'd2);
    trap_pulse_d = pop && e0_q.trap;
    dec_cnt_d    = dec_cnt_q + CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q         <= '0;
      e1_q         <= '0;
      cnt_q        <= 2'd0;
      in_ready_q   <= 1'b1;
      trap_pulse_q <= 1'b0;
      dec_cnt_q    <= '0;
    end else begin
      e0_q         <= e0_d;
      e1_q         <= e1_d;
      cnt_q        <= cnt_d;
      in_ready_q   <= in_ready_d;
      trap_pulse_q <= trap_pulse_d;
      dec_cnt_q    <= dec_cnt_d;
    end
  end

  assign out_pc      = e0_q.pc;
  assign out_op      = e0_q.op;
  assign out_rd      = e0_q.rd;
  assign out_func3   = e0_q.func3;
  assign out_imm     = e0_q.imm;
  assign out_ren     = e0_q.ren;
  assign out_raddr1  = e0_q.raddr1;
  assign out_raddr2  = e0_q.raddr2;
  assign out_wen     = e0_q.wen;
  assign out_trap    = e0_q.trap;
  assign out_illegal = e0_q.illegal;
  assign trap_pulse  = trap_pulse_q;
  assign dec_cnt     = dec_cnt_q;

endmodule

// File: tb/tb_ysyx_23060201_idu_stage.sv
// tb/tb_ysyx_23060201_idu_stage.sv - scoreboard bench: RV32 skid instance and RV64 single-register instance
module tb_ysyx_23060201_idu_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // instance a: XLEN=32, SKID=1, CNT_W=4
  logic        a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
  logic [31:0] a_in_pc = 0, a_in_inst = 0, a_out_pc, a_out_imm;
  logic [6:0]  a_out_op;
  logic [4:0]  a_out_rd, a_out_raddr1, a_out_raddr2;
  logic [2:0]  a_out_func3;
  logic [1:0]  a_out_ren;
  logic        a_out_wen, a_out_trap, a_out_illegal, a_trap_pulse;
  logic [3:0]  a_dec_cnt;

  ysyx_23060201_idu_stage #(.XLEN(32), .SKID(1), .CNT_W(4)) u_a (
    .clk(clk), .rst(rst), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_pc(a_in_pc), .in_inst(a_in_inst), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_pc(a_out_pc), .out_op(a_out_op), .out_rd(a_out_rd), .out_func3(a_out_func3),
    .out_imm(a_out_imm), .out_ren(a_out_ren), .out_raddr1(a_out_raddr1), .out_raddr2(a_out_raddr2),
    .out_wen(a_out_wen), .out_trap(a_out_trap), .out_illegal(a_out_illegal),
    .trap_pulse(a_trap_pulse), .dec_cnt(a_dec_cnt)
  );

  // instance b: XLEN=64, SKID=0, CNT_W=32
  logic        b_flush = 0, b_in_valid = 0, b_in_ready, b_out_valid, b_out_ready = 0;
  logic [63:0] b_in_pc = 0, b_out_pc, b_out_imm;
  logic [31:0] b_in_inst = 0, b_dec_cnt;
  logic [6:0]  b_out_op;
  logic [4:0]  b_out_rd, b_out_raddr1, b_out_raddr2;
  logic [2:0]  b_out_func3;
  logic [1:0]  b_out_ren;
  logic        b_out_wen, b_out_trap, b_out_illegal, b_trap_pulse;

  ysyx_23060201_idu_stage #(.XLEN(64), .SKID(0), .CNT_W(32)) u_b (
    .clk(clk), .rst(rst), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_pc(b_in_pc), .in_inst(b_in_inst), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_pc(b_out_pc), .out_op(b_out_op), .out_rd(b_out_rd), .out_func3(b_out_func3),
    .out_imm(b_out_imm), .out_ren(b_out_ren), .out_raddr1(b_out_raddr1), .out_raddr2(b_out_raddr2),
    .out_wen(b_out_wen), .out_trap(b_out_trap), .out_illegal(b_out_illegal),
    .trap_pulse(b_trap_pulse), .dec_cnt(b_dec_cnt)
  );

  typedef struct {
    logic [63:0] pc, imm;
    logic [6:0]  op;
    logic [4:0]  rd, ra1, ra2;
    logic [2:0]  f3;
    logic [1:0]  ren;
    logic        wen, trap, ill;
  } exp_t;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic exp_t model(input logic [31:0] inst, input logic [63:0] pc, input bit rv64);
    exp_t e;
    e.pc = pc; e.op = inst[6:0]; e.rd = inst[11:7]; e.f3 = inst[14:12];
    e.ra1 = inst[19:15]; e.ra2 = inst[24:20];
    e.trap = (inst == 32'h00100073);
    e.ill = 0; e.ren = 0; e.wen = 0; e.imm = 0;
    case (inst[6:0])
      7'h33: begin e.ren = 2'b11; e.wen = 1; end
      7'h13, 7'h03, 7'h67: begin e.ren = 2'b01; e.wen = 1;
        e.imm = $signed({inst[31:20], 52'b0}) >>> 52; end
      7'h23: begin e.ren = 2'b11; e.imm = $signed({inst[31:25], inst[11:7], 52'b0}) >>> 52; end
      7'h63: begin e.ren = 2'b11;
        e.imm = $signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0, 51'b0}) >>> 51; end
      7'h37: begin e.wen = 1; e.imm = $signed({inst[31:12], 12'b0, 32'b0}) >>> 32; end
      7'h17: begin e.wen = 1; e.f3 = 0; e.imm = $signed({inst[31:12], 12'b0, 32'b0}) >>> 32; end
      7'h6F: begin e.wen = 1; e.f3 = 0;
        e.imm = $signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0, 43'b0}) >>> 43; end
      7'h73: ;
      7'h1B: if (rv64) begin e.ren = 2'b01; e.wen = 1;
               e.imm = $signed({inst[31:20], 52'b0}) >>> 52; end
             else e.ill = 1;
      7'h3B: if (rv64) begin e.ren = 2'b11; e.wen = 1; end else e.ill = 1;
      default: e.ill = 1;
    endcase
    if (e.rd == 0) e.wen = 0;
    if (!rv64) begin e.imm[63:32] = 0; e.pc[63:32] = 0; end
    return e;
  endfunction

  task automatic cmp_bundle(input string tag, input exp_t e, input logic [63:0] pc, input logic [63:0] imm,
                            input logic [6:0] op, input logic [4:0] rd, input logic [4:0] ra1,
                            input logic [4:0] ra2, input logic [2:0] f3, input logic [1:0] ren,
                            input logic wen, input logic trap, input logic ill);
    check({tag, "_pc"}, pc, e.pc);
    check({tag, "_imm"}, imm, e.imm);
    check({tag, "_fields"}, 64'({op, rd, f3, ra1, ra2}), 64'({e.op, e.rd, e.f3, e.ra1, e.ra2}));
    check({tag, "_ctl"}, 64'({ren, wen, trap, ill}), 64'({e.ren, e.wen, e.trap, e.ill}));
  endtask

  exp_t qa[$], qb[$];
  exp_t ea, eb;
  int   a_xfers = 0, b_xfers = 0;
  logic a_pend_trap = 0, b_pend_trap = 0;

  always @(negedge clk) begin
    if (rst) begin
      qa.delete(); a_xfers = 0; a_pend_trap = 0;
    end else begin
      check("a_dec_cnt", 64'(a_dec_cnt), 64'(a_xfers[3:0]));
      check("a_trap_pulse", 64'(a_trap_pulse), 64'(a_pend_trap));
      a_pend_trap = 0;
      if (a_out_valid && a_out_ready) begin
        if (qa.size() == 0) check("a_unexpected_out", 1, 0);
        else begin
          ea = qa.pop_front();
          cmp_bundle("a", ea, {32'b0, a_out_pc}, {32'b0, a_out_imm}, a_out_op, a_out_rd, a_out_raddr1,
                     a_out_raddr2, a_out_func3, a_out_ren, a_out_wen, a_out_trap, a_out_illegal);
          a_pend_trap = ea.trap;
        end
        a_xfers++;
      end
      if (a_flush) qa.delete();
      else if (a_in_valid && a_in_ready) qa.push_back(model(a_in_inst, {32'b0, a_in_pc}, 0));
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      qb.delete(); b_xfers = 0; b_pend_trap = 0;
    end else begin
      check("b_dec_cnt", 64'(b_dec_cnt), 64'(b_xfers));
      check("b_trap_pulse", 64'(b_trap_pulse), 64'(b_pend_trap));
      b_pend_trap = 0;
      if (b_out_valid && b_out_ready) begin
        if (qb.size() == 0) check("b_unexpected_out", 1, 0);
        else begin
          eb = qb.pop_front();
          cmp_bundle("b", eb, b_out_pc, b_out_imm, b_out_op, b_out_rd, b_out_raddr1,
                     b_out_raddr2, b_out_func3, b_out_ren, b_out_wen, b_out_trap, b_out_illegal);
          b_pend_trap = eb.trap;
        end
        b_xfers++;
      end
      if (b_flush) qb.delete();
      else if (b_in_valid && b_in_ready) qb.push_back(model(b_in_inst, b_in_pc, 1));
    end
  end

  logic [6:0] ops [14] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h37, 7'h17,
                           7'h6F, 7'h67, 7'h73, 7'h1B, 7'h3B, 7'h0B, 7'h7F};

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 9) == 0) return 32'h00100073;
    r[6:0] = ops[$urandom_range(0, 13)];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (3) tick();
    rst = 0;
    check("rst_out_valid", 64'(a_out_valid), 0);
    check("rst_in_ready", 64'(a_in_ready), 1);
    check("rst_dec_cnt", 64'(a_dec_cnt), 0);
    check("rst_trap_pulse", 64'(a_trap_pulse), 0);
    check("rst_out_pc", 64'(a_out_pc), 0);

    // addi x1,x0,-1
    a_out_ready = 1; a_in_valid = 1; a_in_pc = 32'h80000000; a_in_inst = 32'hFFF00093;
    tick();
    a_in_valid = 0;
    check("addi_valid", 64'(a_out_valid), 1);
    check("addi_imm", 64'(a_out_imm), 64'hFFFFFFFF);
    check("addi_ren", 64'(a_out_ren), 1);
    check("addi_wen", 64'(a_out_wen), 1);
    check("addi_rd", 64'(a_out_rd), 1);
    tick();
    check("addi_cnt", 64'(a_dec_cnt), 1);
    check("addi_drained", 64'(a_out_valid), 0);

    // skid fill with three back-to-back beats
    a_out_ready = 0;
    a_in_valid = 1; a_in_pc = 32'h100; a_in_inst = 32'h00208033;
    tick();
    check("skid_ready1", 64'(a_in_ready), 1);
    a_in_pc = 32'h104; a_in_inst = 32'h00310113;
    tick();
    check("skid_full", 64'(a_in_ready), 0);
    a_in_pc = 32'h108; a_in_inst = 32'h0020A423;
    tick();
    check("skid_hold_ready", 64'(a_in_ready), 0);
    check("skid_hold_pc", 64'(a_out_pc), 32'h100);
    a_out_ready = 1;
    tick();
    check("skid_pop1_pc", 64'(a_out_pc), 32'h104);
    check("skid_pop1_ready", 64'(a_in_ready), 1);
    tick();
    a_in_valid = 0;
    check("skid_pop2_pc", 64'(a_out_pc), 32'h108);
    tick();
    check("skid_empty", 64'(a_out_valid), 0);

    // ebreak and trap pulse
    a_in_valid = 1; a_in_pc = 32'h200; a_in_inst = 32'h00100073;
    tick();
    a_in_valid = 0;
    check("ebreak_trap", 64'(a_out_trap), 1);
    check("ebreak_pulse0", 64'(a_trap_pulse), 0);
    tick();
    check("ebreak_pulse1", 64'(a_trap_pulse), 1);
    tick();
    check("ebreak_pulse2", 64'(a_trap_pulse), 0);

    // addiw is illegal on RV32
    a_in_valid = 1; a_in_pc = 32'h300; a_in_inst = 32'hFFE0029B;
    tick();
    a_in_valid = 0;
    check("rv32_addiw_ill", 64'(a_out_illegal), 1);
    check("rv32_addiw_ren", 64'(a_out_ren), 0);
    check("rv32_addiw_wen", 64'(a_out_wen), 0);
    check("rv32_addiw_imm", 64'(a_out_imm), 0);
    tick();

    // flush with two entries, then with one entry
    a_out_ready = 0;
    a_in_valid = 1; a_in_pc = 32'h400; a_in_inst = 32'h00000013;
    tick();
    a_in_pc = 32'h404;
    tick();
    a_in_pc = 32'h408; a_flush = 1;
    tick();
    a_flush = 0; a_in_valid = 0;
    check("flush2_valid", 64'(a_out_valid), 0);
    check("flush2_ready", 64'(a_in_ready), 1);
    a_in_valid = 1; a_in_pc = 32'h40C;
    tick();
    a_in_pc = 32'h410; a_flush = 1;
    tick();
    a_flush = 0; a_in_valid = 0;
    check("flush1_valid", 64'(a_out_valid), 0);
    a_out_ready = 1;
    repeat (3) tick();
    check("flush_no_ghost", 64'(a_out_valid), 0);

    // reset mid-operation with buffered entries
    a_out_ready = 0; a_in_valid = 1; a_in_pc = 32'h500;
    repeat (2) tick();
    rst = 1; a_in_valid = 0;
    repeat (2) tick();
    rst = 0;
    check("midrst_valid", 64'(a_out_valid), 0);
    check("midrst_cnt", 64'(a_dec_cnt), 0);
    check("midrst_ready", 64'(a_in_ready), 1);

    // 17 transfers wrap a 4-bit counter; first is sw x2,8(x1)
    a_out_ready = 1; a_in_valid = 1; a_in_pc = 32'h1000; a_in_inst = 32'h0020A423;
    tick();
    check("sw_imm", 64'(a_out_imm), 8);
    check("sw_ren", 64'(a_out_ren), 3);
    check("sw_wen", 64'(a_out_wen), 0);
    for (int i = 1; i < 17; i++) begin
      a_in_pc = 32'h1000 + 32'(i * 4); a_in_inst = rand_inst();
      tick();
    end
    a_in_valid = 0;
    tick();
    check("wrap_cnt", 64'(a_dec_cnt), 1);

    // randomized traffic with back-pressure and occasional flush
    for (int i = 0; i < 300; i++) begin
      a_in_valid  = ($urandom_range(0, 3) != 0);
      a_in_inst   = rand_inst();
      a_in_pc     = {$urandom, 2'b00} >> 2 << 2;
      a_out_ready = ($urandom_range(0, 3) != 0);
      a_flush     = ($urandom_range(0, 19) == 0);
      tick();
    end
    a_in_valid = 0; a_flush = 0; a_out_ready = 1;
    repeat (4) tick();
    check("a_queue_drained", 64'(qa.size()), 0);

    // RV64 instance
    b_out_ready = 1; b_in_valid = 1; b_in_pc = 64'h0000000080000010; b_in_inst = 32'hFFDFF06F;
    tick();
    check("jal_imm", b_out_imm, 64'hFFFFFFFFFFFFFFFC);
    check("jal_f3", 64'(b_out_func3), 0);
    check("jal_wen", 64'(b_out_wen), 0);
    check("jal_pc", b_out_pc, 64'h0000000080000010);
    b_in_inst = 32'hFFE0029B;
    tick();
    check("addiw_ill", 64'(b_out_illegal), 0);
    check("addiw_imm", b_out_imm, 64'hFFFFFFFFFFFFFFFE);
    check("addiw_wen", 64'(b_out_wen), 1);
    b_in_inst = 32'h800000B7;
    tick();
    check("lui64_imm", b_out_imm, 64'hFFFFFFFF80000000);
    b_out_ready = 0; b_in_inst = 32'h00000013;
    tick();
    b_in_valid = 0;
    check("s0_blocked", 64'(b_in_ready), 0);
    b_out_ready = 1;
    #1;
    check("s0_ready_comb", 64'(b_in_ready), 1);
    tick();
    for (int i = 0; i < 200; i++) begin
      b_in_valid  = ($urandom_range(0, 3) != 0);
      b_in_inst   = rand_inst();
      b_in_pc     = {$urandom, $urandom};
      b_out_ready = ($urandom_range(0, 3) != 0);
      b_flush     = ($urandom_range(0, 19) == 0);
      tick();
    end
    b_in_valid = 0; b_flush = 0; b_out_ready = 1;
    repeat (3) tick();
    check("b_queue_drained", 64'(qb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ysyx_23060201_idu_stage.md
Name: ysyx_23060201_idu_stage

Overview:
Pipelined, parametrised instruction-decode stage for the NPC core, sitting between IFU and EXU. It accepts {pc, inst} over a valid/ready handshake and decodes opcode class, immediate (sign-extended to XLEN), rs1/rs2 read enables, rd write enable and func3. It adds ebreak/illegal detection and a transfer counter, and presents a registered decode bundle through an optional 2-entry skid buffer. Supports RV32I/RV64I via XLEN and a single-cycle flush for redirects.

Parameters:
XLEN, 32, datapath width: 32 or 64; immediates and pc are XLEN wide.
SKID, 1, 1 = 2-entry skid buffer (in_ready registered); 0 = single pipeline register.
CNT_W, 32, width of the decoded-instruction counter.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard all buffered entries and the input beat of this cycle
in_valid  in  1  IFU beat valid
in_ready  out  1  stage can accept a beat
in_pc  in  XLEN  pc of inst
in_inst  in  32  instruction word
out_valid  out  1  decode bundle valid
out_ready  in  1  EXU accepts bundle
out_pc  out  XLEN  pc passthrough
out_op  out  7  inst[6:0]
out_rd  out  5  inst[11:7]
out_func3  out  3  inst[14:12]; forced 0 for AUIPC and JAL
out_imm  out  XLEN  selected immediate
out_ren  out  2  bit0 = rs1 read, bit1 = rs2 read
out_raddr1  out  5  inst[19:15]
out_raddr2  out  5  inst[24:20]
out_wen  out  1  rd write enable
out_trap  out  1  inst == 32'h00100073 (ebreak)
out_illegal  out  1  opcode not in supported set
trap_pulse  out  1  one-cycle pulse when a trap bundle transfers out
dec_cnt  out  CNT_W  count of bundles transferred out

Behaviour:
- Reset: out_valid=0, trap_pulse=0, dec_cnt=0, skid entries empty; in_ready=1 in the cycle after rst deasserts. Data outputs are don't-care while out_valid=0 but reset to 0.
- Decode is combinational on the input beat and registered on acceptance (in_valid && in_ready && !flush). Latency: accepted beat appears at out_valid the next cycle.
- Opcode classes and {ren, wen}: R 0110011 {11,1}; I 0010011 {01,1}; LOAD 0000011 {01,1}; S 0100011 {11,0}; B 1100011 {11,0}; LUI 0110111 {00,1}; AUIPC 0010111 {00,1}; JAL 1101111 {00,1}; JALR 1100111 {01,1}; SYSTEM 1110011 {00,0}. XLEN=64 only: OP-IMM-32 0011011 {01,1}, OP-32 0111011 {11,1}.
- Any other opcode, or a 64-bit-only opcode with XLEN=32: out_illegal=1, ren=00, wen=0, imm=0.
- wen forced 0 when rd==0.
- Immediates, each sign-extended from inst[31] to XLEN: I {inst[31:20]} for I/LOAD/JALR/OP-IMM-32; S {inst[31:25],inst[11:7]}; B {inst[7],inst[30:25],inst[11:8],0}; U {inst[31:12],12'b0} for LUI/AUIPC; J {inst[19:12],inst[20],inst[30:21],0}; R/OP-32/SYSTEM imm=0.
- SKID=1: two-entry FIFO; in_ready = !full, which is registered and does not depend on out_ready. Simultaneous push and pop with one entry keeps count at 1. Order is preserved.
- SKID=0: single register; in_ready = !out_valid || out_ready.
- Transfer out = out_valid && out_ready. out_* stable while out_valid && !out_ready.
- flush: next cycle out_valid=0 and all entries are empty; the input beat in the flush cycle is dropped; a transfer out in the flush cycle still counts. flush has priority over push.
- trap_pulse: 1 in the cycle after a transfer of a bundle with out_trap=1; else 0.
- dec_cnt += 1 per transfer out, wrapping modulo 2^CNT_W.
- rst mid-operation overrides flush and all handshakes; buffered entries are lost.

Test Plan:
- Reset, then push addi x1,x0,-1 (32'hFFF00093) at pc 32'h80000000 with out_ready=1 -> next cycle out_valid=1, imm=32'hFFFFFFFF, ren=01, wen=1, rd=1, dec_cnt becomes 1.
- SKID=1, out_ready=0, push 3 beats back-to-back -> in_ready drops after 2 accepted. Set out_ready=1 -> beats emerge in order, no loss or duplicate.
- XLEN=64, push jal x0,-4 (32'hFFDFF06F) -> imm=64'hFFFFFFFFFFFFFFFC, func3=0, wen=0 (rd=0). Push addiw (opcode 0011011) with XLEN=32 -> out_illegal=1.
- Push ebreak 32'h00100073 with out_ready=1 -> out_trap=1, then trap_pulse=1 for exactly one cycle.
- Two entries buffered, assert flush together with in_valid -> next cycle out_valid=0 and in_ready=1; the flushed-cycle beat never appears.
- CNT_W=4, 17 transfers -> dec_cnt=1 (wraps). sw x2,8(x1) (32'h0020A423) -> imm=8, ren=11, wen=0.
